obi_tagmem_model: RTL and testbench

OBI_TAGMEM_MODEL -- requirements
Module: obi_tagmem_model

---
 rtl/obi_tagmem_model.sv | 210 +++++++++++++++++++++
 tb/tb_obi_tagmem_model.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_tagmem_model.sv
// obi_tagmem_model
//   Behavioural OBI data-port memory with a tag bit in the top data bit.
//   Grant wait and response delay are drawn pseudo-randomly from a 32-bit
//   Galois LFSR. Responses are queued in a small FIFO and return in grant order.
//
//   Optional feature: define TAGMEM_ERR_INJ_EN to enable random error
//   injection controlled by ERR_RATE and err_enable. Without it both inputs
//   are ignored and only out-of-range accesses report an error.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   GNT_WMAX, RESP_WMAX      maximum grant wait / extra response wait (cycles)
//   ERR_RATE, err_enable     error-injection controls
//   data_req/we/be/addr/wdata  request channel
//   data_gnt                 request accepted this cycle
//   data_rvalid/rdata/err    one-cycle response strobe with payload
module obi_tagmem_model #(
    parameter int          DW          = 33,
    parameter int          MEM_AW      = 16,
    parameter int          OUTSTANDING = 4,
    parameter logic [31:0] LFSR_SEED   = 32'h1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    GNT_WMAX,
    input  logic [3:0]    RESP_WMAX,
    input  logic [2:0]    ERR_RATE,
    input  logic          err_enable,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [3:0]    data_be,
    input  logic [31:0]   data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_gnt,
    output logic          data_rvalid,
    output logic [DW-1:0] data_rdata,
    output logic          data_err
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic [3:0]    delay;
    } resp_t;

    typedef enum logic {
        GNT_IDLE,
        GNT_WAIT
    } gnt_state_e;

    logic [DW-1:0]    mem_q [DEPTH];
    resp_t            fifo_q [OUTSTANDING];
    logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      lfsr_q, lfsr_d;
    gnt_state_e       gntState_q, gntState_d;
    logic [3:0]       gntCnt_q, gntCnt_d;

    logic [31:0]       gntDraw, respDraw;
    logic [3:0]        waitLeft;
    logic              grant;
    logic              fifoFull, headValid, pop;
    resp_t             head, pushEntry;
    logic [MEM_AW-1:0] wordIdx;
    logic              outOfRange, injErr, accErr, memWrite;
    logic [DW-1:0]     memWord, newWord;

    // Galois LFSR, taps 32,22,2,1 (right-shifting form), free-running.
    assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gntDraw  = lfsr_q % ({28'd0, GNT_WMAX} + 32'd1);
    assign respDraw = lfsr_q % ({28'd0, RESP_WMAX} + 32'd1);

    // Grant-wait FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gntState_q <= GNT_IDLE;
            gntCnt_q   <= 4'd0;
        end else begin
            gntState_q <= gntState_d;
            gntCnt_q   <= gntCnt_d;
        end
    end

    // Grant-wait FSM: next state. A fresh request draws its wait this cycle,
    // so a zero draw grants immediately; dropping the request abandons it.
    always_comb begin
        gntState_d = gntState_q;
        gntCnt_d   = gntCnt_q;
        if (!data_req || grant) begin
            gntState_d = GNT_IDLE;
            gntCnt_d   = 4'd0;
        end else begin
            gntState_d = GNT_WAIT;
            gntCnt_d   = (waitLeft == 4'd0) ? 4'd0 : waitLeft - 4'd1;
        end
    end

    // Grant-wait FSM: outputs. Grant is forced low while reset is asserted.
    always_comb begin
        waitLeft = (gntState_q == GNT_WAIT) ? gntCnt_q : gntDraw[3:0];
        grant    = rst_n && data_req && !fifoFull && (waitLeft == 4'd0);
    end

    assign data_gnt = grant;

    // Access decode; upper address bits beyond the memory are an error.
    assign wordIdx    = data_addr[MEM_AW+1:2];
    assign outOfRange = (data_addr >> (MEM_AW + 2)) != 32'd0;
    assign memWord    = mem_q[wordIdx];

`ifdef TAGMEM_ERR_INJ_EN
    logic [7:0] injMask;
    assign injMask = 8'hFF >> ERR_RATE;
    assign injErr  = err_enable && (ERR_RATE != 3'd0) && !outOfRange
                     && ((lfsr_q[7:0] & injMask) == 8'd0);
`else
    logic unusedInjInputs;
    assign injErr          = 1'b0;
    assign unusedInjInputs = ^{ERR_RATE, err_enable};
`endif

    assign accErr = outOfRange || injErr;

    // Full-word writes take the tag from wdata; partial writes clear it.
    always_comb begin
        newWord = memWord;
        if (data_be == 4'hF) begin
            newWord = data_wdata;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (data_be[b]) begin
                    newWord[8*b +: 8] = data_wdata[8*b +: 8];
                end
            end
            newWord[DW-1] = 1'b0;
        end
    end

    assign memWrite = grant && data_we && !accErr && (data_be != 4'h0);

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem_q[wordIdx] <= newWord;
        end
    end

    // Write responses carry no data; errored responses carry zero data.
    always_comb begin
        pushEntry       = '0;
        pushEntry.rdata = (!data_we && !accErr) ? memWord : '0;
        pushEntry.err   = accErr;
        pushEntry.delay = respDraw[3:0];
    end

    assign fifoFull  = (count_q == CNT_W'(OUTSTANDING));
    assign headValid = (count_q != '0);
    assign head      = fifo_q[rdPtr_q];
    assign pop       = headValid && (head.delay == 4'd0);

    // Response FIFO. Only the head's delay counts down, so later entries
    // start their wait once they reach the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (grant) begin
                fifo_q[wrPtr_q] <= pushEntry;
                wrPtr_q <= (wrPtr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wrPtr_q + PTR_W'(1);
            end
            if (headValid && (head.delay != 4'd0)) begin
                fifo_q[rdPtr_q].delay <= head.delay - 4'd1;
            end
            if (pop) begin
                rdPtr_q <= (rdPtr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rdPtr_q + PTR_W'(1);
            end
            case ({grant, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_rvalid = pop;
    assign data_rdata  = pop ? head.rdata : '0;
    assign data_err    = pop && head.err;

    logic unusedBits;
    assign unusedBits = ^{data_addr[1:0], gntDraw[31:4], respDraw[31:4]};

endmodule

// File: tb/tb_obi_tagmem_model.sv
// tb_obi_tagmem_model
//   Directed bench for obi_tagmem_model with hand-computed expectations.
//   Covers reset, tagged full/partial writes, out-of-range errors, ordering
//   with several outstanding responses, reset discarding pending responses,
//   and error injection (section chosen by TAGMEM_ERR_INJ_EN).
module tb_obi_tagmem_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  GNT_WMAX, RESP_WMAX;
    logic [2:0]  ERR_RATE;
    logic        err_enable;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [32:0] data_wdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [32:0] data_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    obi_tagmem_model #(
        .DW(33), .MEM_AW(16), .OUTSTANDING(4), .LFSR_SEED(32'h1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .GNT_WMAX(GNT_WMAX), .RESP_WMAX(RESP_WMAX),
        .ERR_RATE(ERR_RATE), .err_enable(err_enable),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [32:0] wdata);
        data_req   = req;
        data_we    = we;
        data_be    = be;
        data_addr  = addr;
        data_wdata = wdata;
    endtask

    // Single access, called just after a rising edge. gntWait counts falling
    // edges before the grant (0 = same cycle); respLat counts cycles from the
    // granting edge to the response (1 = minimum).
    task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [32:0] wdata, output logic [32:0] rdata,
                          output logic err, output int gntWait, output int respLat);
        applyStimulus(1'b1, we, be, addr, wdata);
        gntWait = 0;
        @(negedge clk);
        while (!data_gnt && gntWait < 40) begin
            @(negedge clk);
            gntWait++;
        end
        if (!data_gnt) checkOutput("gnt_timeout", 64'(data_gnt), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 33'h0);
        respLat = 1;
        @(negedge clk);
        while (!data_rvalid && respLat < 40) begin
            @(negedge clk);
            respLat++;
        end
        if (!data_rvalid) checkOutput("rvalid_timeout", 64'(data_rvalid), 64'd1);
        rdata = data_rdata;
        err   = data_err;
        @(posedge clk);
        #1;
    endtask

    logic [32:0] rd;
    logic        er;
    int          gw, rl;
    logic [31:0] ordAddr [6];
    logic [32:0] ordData [6];
    logic [32:0] shadow  [16];

    initial begin
        int gIdx, rIdx, grantsBefore, extra, errCount;
        logic firstSeen, gotG;

        // Reset with a request held high: grant must stay low.
        rst_n = 1'b0;
        GNT_WMAX = 4'd0; RESP_WMAX = 4'd0; ERR_RATE = 3'd0; err_enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 33'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_gnt", 64'(data_gnt), 64'd0);
        checkOutput("reset_rvalid", 64'(data_rvalid), 64'd0);
        checkOutput("reset_rdata", 64'(data_rdata), 64'd0);
        checkOutput("reset_err", 64'(data_err), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 33'h0);
        rst_n = 1'b1;

        // Zero-wait write then read of a tagged word.
        access(1'b1, 4'hF, 32'h10, 33'h1_DEADBEEF, rd, er, gw, rl);
        checkOutput("wr10_gntwait", 64'(gw), 64'd0);
        checkOutput("wr10_latency", 64'(rl), 64'd1);
        checkOutput("wr10_err", 64'(er), 64'd0);
        access(1'b0, 4'hF, 32'h10, 33'h0, rd, er, gw, rl);
        checkOutput("rd10_gntwait", 64'(gw), 64'd0);
        checkOutput("rd10_latency", 64'(rl), 64'd1);
        checkOutput("rd10_rdata", 64'(rd), 64'h1_DEADBEEF);
        checkOutput("rd10_err", 64'(er), 64'd0);
        @(negedge clk);
        checkOutput("idle_rvalid", 64'(data_rvalid), 64'd0);
        checkOutput("idle_rdata", 64'(data_rdata), 64'd0);
        @(posedge clk);
        #1;

        // Partial write clears the tag and merges only enabled bytes.
        access(1'b1, 4'hF, 32'h20, 33'h1_12345678, rd, er, gw, rl);
        access(1'b1, 4'h1, 32'h20, 33'h0_000000AA, rd, er, gw, rl);
        access(1'b0, 4'hF, 32'h20, 33'h0, rd, er, gw, rl);
        checkOutput("rd20_partial", 64'(rd), 64'h0_123456AA);
        access(1'b1, 4'h0, 32'h20, 33'h1_FFFFFFFF, rd, er, gw, rl);
        access(1'b0, 4'hF, 32'h20, 33'h0, rd, er, gw, rl);
        checkOutput("rd20_be0_unchanged", 64'(rd), 64'h0_123456AA);
        access(1'b1, 4'h6, 32'h10, 33'h1_11223344, rd, er, gw, rl);
        access(1'b0, 4'hF, 32'h10, 33'h0, rd, er, gw, rl);
        checkOutput("rd10_be6", 64'(rd), 64'h0_DE2233EF);

        // Out-of-range accesses error, return zero and leave memory alone.
        access(1'b0, 4'hF, 32'h0004_0000, 33'h0, rd, er, gw, rl);
        checkOutput("oor_rd_err", 64'(er), 64'd1);
        checkOutput("oor_rd_rdata", 64'(rd), 64'd0);
        access(1'b1, 4'hF, 32'h0004_0010, 33'h1_CAFEF00D, rd, er, gw, rl);
        checkOutput("oor_wr_err", 64'(er), 64'd1);
        access(1'b0, 4'hF, 32'h10, 33'h0, rd, er, gw, rl);
        checkOutput("oor_wr_no_alias", 64'(rd), 64'h0_DE2233EF);
        access(1'b0, 4'hF, 32'h8000_0010, 33'h0, rd, er, gw, rl);
        checkOutput("oor_msb_err", 64'(er), 64'd1);
        access(1'b1, 4'hF, 32'h0003_FFFC, 33'h1_0BADF00D, rd, er, gw, rl);
        checkOutput("top_wr_err", 64'(er), 64'd0);
        access(1'b0, 4'hF, 32'h0003_FFFC, 33'h0, rd, er, gw, rl);
        checkOutput("top_rd_rdata", 64'(rd), 64'h1_0BADF00D);

        // Six back-to-back reads with long random response delays.
        ordAddr = '{32'h10, 32'h20, 32'h3FFFC, 32'h10, 32'h20, 32'h3FFFC};
        ordData = '{33'h0_DE2233EF, 33'h0_123456AA, 33'h1_0BADF00D,
                    33'h0_DE2233EF, 33'h0_123456AA, 33'h1_0BADF00D};
        RESP_WMAX = 4'd15;
        gIdx = 0; rIdx = 0; grantsBefore = 0; firstSeen = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'hF, ordAddr[0], 33'h0);
        for (int c = 0; c < 300 && rIdx < 6; c++) begin
            @(negedge clk);
            gotG = data_gnt;
            if (data_rvalid) begin
                checkOutput($sformatf("order_rdata%0d", rIdx), 64'(data_rdata), 64'(ordData[rIdx]));
                rIdx++;
                firstSeen = 1'b1;
            end
            if (gotG && !firstSeen) grantsBefore++;
            @(posedge clk);
            #1;
            if (gotG) begin
                gIdx++;
                if (gIdx < 6) applyStimulus(1'b1, 1'b0, 4'hF, ordAddr[gIdx], 33'h0);
                else applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 33'h0);
            end
        end
        checkOutput("order_resp_count", 64'(rIdx), 64'd6);
        checkOutput("order_max4_before_first", 64'(grantsBefore <= 4), 64'd1);

        // Grant three reads, then reset with them possibly still pending.
        gIdx = 0;
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h20, 33'h0);
        for (int c = 0; c < 100 && gIdx < 3; c++) begin
            @(negedge clk);
            gotG = data_gnt;
            @(posedge clk);
            #1;
            if (gotG) gIdx++;
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 33'h0);
        GNT_WMAX = 4'd15;
        @(negedge clk);
        checkOutput("rst2_rvalid", 64'(data_rvalid), 64'd0);
        checkOutput("rst2_err", 64'(data_err), 64'd0);
        @(posedge clk);
        #1;
        // From seed 1: wait = 1 mod 16 = 1; next state 0x80200003 gives delay 3.
        rst_n = 1'b1;
        access(1'b0, 4'hF, 32'h10, 33'h0, rd, er, gw, rl);
        checkOutput("seed_gntwait", 64'(gw), 64'd1);
        checkOutput("seed_latency", 64'(rl), 64'd4);
        checkOutput("seed_rdata", 64'(rd), 64'h0_DE2233EF);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (data_rvalid) extra++;
        end
        checkOutput("rst2_no_stale_rvalid", 64'(extra), 64'd0);
        @(posedge clk);
        #1;

        GNT_WMAX = 4'd0; RESP_WMAX = 4'd0; ERR_RATE = 3'd7;
`ifdef TAGMEM_ERR_INJ_EN
        // Seed a region with injection off, then hammer it with injection on.
        err_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = {1'b0, 32'hA500_0000 | 32'(i)};
            access(1'b1, 4'hF, 32'h1000 + 32'(4 * i), shadow[i], rd, er, gw, rl);
        end
        err_enable = 1'b1;
        errCount = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [32:0] val;
            val = {1'(i & 1), 16'h5A5A, 16'(i)};
            access(1'b1, 4'hF, 32'h1000 + 32'(4 * (i % 16)), val, rd, er, gw, rl);
            if (er) errCount++;
            else shadow[i % 16] = val;
        end
        err_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 4'hF, 32'h1000 + 32'(4 * i), 33'h0, rd, er, gw, rl);
            checkOutput($sformatf("inj_readback%0d", i), 64'(rd), 64'(shadow[i]));
        end
        checkOutput("inj_rate_in_band", 64'(errCount >= 400 && errCount <= 600), 64'd1);
        $display("[TB] injected errors: %0d of 1000", errCount);
`else
        // Without the feature, injection controls must have no effect.
        err_enable = 1'b1;
        errCount = 0;
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 4'hF, 32'h1000 + 32'(4 * i), 33'h1_0000_0000 | 33'(i), rd, er, gw, rl);
            if (er) errCount++;
        end
        checkOutput("noinj_err_count", 64'(errCount), 64'd0);
        access(1'b0, 4'hF, 32'h1000 + 32'(4 * 15), 33'h0, rd, er, gw, rl);
        checkOutput("noinj_readback", 64'(rd), 64'h1_0000_000F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
